// File: rtl/pipe_pkg.sv
// Shared types and limits for the pipeline register chain.
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 8;
    localparam int PIPE_DATAW     = 32;
    localparam int PIPE_CTRLW     = 2;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_CTRLW-1:0] ctrl;
        logic [PIPE_DATAW-1:0] data;
    } pipe_entry_t;

    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_stage.sv
// One pipeline stage: main entry plus an optional skid entry.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int CTRLW = 2,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTRLW-1:0] in_ctrl,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTRLW-1:0] out_ctrl,
    output logic [DATAW-1:0] out_data,
    output logic [1:0]       count
);

    typedef struct packed {
        logic             valid;
        logic [CTRLW-1:0] ctrl;
        logic [DATAW-1:0] data;
    } entry_t;

    localparam entry_t EMPTY = '0;

    entry_t main_q;
    entry_t main_d;
    entry_t in_e;

    assign in_e      = {1'b1, in_ctrl, in_data};
    assign out_valid = main_q.valid;
    assign out_ctrl  = main_q.valid ? main_q.ctrl : '0;
    assign out_data  = main_q.data;

    generate
        if (SKID != 0) begin : g_skid
            entry_t skid_q;
            entry_t skid_d;
            logic   take;
            logic   accept;

            // Ready comes straight from a flop to cut the ready path.
            assign in_ready = !skid_q.valid;
            assign take     = main_q.valid && out_ready;
            assign accept   = in_valid && !skid_q.valid;
            assign count    = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

            always_comb begin
                main_d = main_q;
                skid_d = skid_q;
                if (flush) begin
                    main_d = EMPTY;
                    skid_d = EMPTY;
                end else if (take) begin
                    if (skid_q.valid) begin
                        main_d = skid_q;
                        skid_d = EMPTY;
                    end else if (accept) begin
                        main_d = in_e;
                    end else begin
                        main_d.valid = 1'b0;
                    end
                end else if (accept) begin
                    if (main_q.valid) skid_d = in_e;
                    else              main_d = in_e;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q <= EMPTY;
                    skid_q <= EMPTY;
                end else begin
                    main_q <= main_d;
                    skid_q <= skid_d;
                end
            end
        end else begin : g_plain
            logic accept;

            // An empty stage loads even while downstream is stalled.
            assign in_ready = !main_q.valid || out_ready;
            assign accept   = in_valid && in_ready;
            assign count    = {1'b0, main_q.valid};

            always_comb begin
                main_d = main_q;
                if (flush) begin
                    main_d = EMPTY;
                end else if (accept) begin
                    main_d = in_e;
                end else if (in_ready) begin
                    main_d.valid = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) main_q <= EMPTY;
                else        main_q <= main_d;
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH handshaked pipeline stages with flush and
// an occupancy count over main and skid entries.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int CTRLW = 2,
    parameter int DEPTH = 1,
    parameter int SKID  = 1,
    parameter int OCCW  = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTRLW-1:0] in_ctrl,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTRLW-1:0] out_ctrl,
    output logic [DATAW-1:0] out_data,
    output logic [OCCW-1:0]  occupancy
);

    generate
        if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
            $error("pipe_stage_chain: DEPTH must be 1..%0d", PIPE_MAX_DEPTH);
        end
    endgenerate

    logic             v [DEPTH+1];
    logic             r [DEPTH+1];
    logic [CTRLW-1:0] c [DEPTH+1];
    logic [DATAW-1:0] d [DEPTH+1];
    logic [1:0]       cnt [DEPTH];

    assign v[0]      = in_valid;
    assign c[0]      = in_ctrl;
    assign d[0]      = in_data;
    assign in_ready  = r[0];
    assign out_valid = v[DEPTH];
    assign out_ctrl  = c[DEPTH];
    assign out_data  = d[DEPTH];
    assign r[DEPTH]  = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_stage #(
            .DATAW (DATAW),
            .CTRLW (CTRLW),
            .SKID  (SKID)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (v[i]),
            .in_ready  (r[i]),
            .in_ctrl   (c[i]),
            .in_data   (d[i]),
            .out_valid (v[i+1]),
            .out_ready (r[i+1]),
            .out_ctrl  (c[i+1]),
            .out_data  (d[i+1]),
            .count     (cnt[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCCW'(cnt[i]);
        end
    end

endmodule
